// File: rtl/dual_port_ram.sv
// dual_port_ram: simple-dual-port synchronous RAM (one write port, one read port, one clock).
// Adds per-byte write enables, selectable read-during-write behaviour and a clear sweep
// that writes CLEAR_VAL to every word after reset or on request.
//
// Parameters:
//   DATA      - word width in bits, must be a multiple of 8
//   ADDR      - address width, depth = 2**ADDR words
//   RDW_MODE  - same-address collision: 0 = read-first (old word), 1 = write-first (merged word)
//   CLEAR_VAL - value written to every word by the clear sweep
//
// Ports:
//   clk       - clock, all activity on the rising edge
//   reset     - synchronous active-high reset, also starts a clear sweep
//   wr_en     - write request
//   wr_addr   - write address
//   wr_be     - byte enables, bit i gates wr_data[8i+7:8i]
//   wr_data   - write data
//   rd_en     - read request
//   rd_addr   - read address
//   rd_data   - registered read data
//   rd_valid  - high for one cycle when rd_data carries a new read result
//   clear_req - single-cycle request to start a clear sweep
//   busy      - high while the clear sweep runs; both ports are ignored meanwhile
module dual_port_ram #(
    parameter int unsigned     DATA      = 16,
    parameter int unsigned     ADDR      = 4,
    parameter int unsigned     RDW_MODE  = 0,
    parameter logic [DATA-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR-1:0]   wr_addr,
    input  logic [DATA/8-1:0] wr_be,
    input  logic [DATA-1:0]   wr_data,
    input  logic              rd_en,
    input  logic [ADDR-1:0]   rd_addr,
    output logic [DATA-1:0]   rd_data,
    output logic              rd_valid,
    input  logic              clear_req,
    output logic              busy
);

    localparam int unsigned     NumBytes = DATA / 8;
    localparam int unsigned     Depth    = 2 ** ADDR;
    localparam logic [ADDR-1:0] LastAddr = '1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    logic [DATA-1:0] mem [Depth];

    state_e          state_q;
    logic [ADDR-1:0] cnt_q;
    logic            busy_q;
    logic [DATA-1:0] rd_data_q;
    logic            rd_valid_q;

    logic [DATA-1:0] wr_old;
    logic [DATA-1:0] wr_merged;
    logic [DATA-1:0] rd_word;

    // Word as it will look after the current write: enabled bytes from wr_data, rest kept.
    always_comb begin
        wr_old    = mem[wr_addr];
        wr_merged = wr_old;
        for (int i = 0; i < NumBytes; i++) begin
            if (wr_be[i]) begin
                wr_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // Write-first mode forwards the merged word on a same-address collision.
    always_comb begin
        rd_word = mem[rd_addr];
        if ((RDW_MODE == 1) && wr_en && (wr_addr == rd_addr)) begin
            rd_word = wr_merged;
        end
    end

    // Storage has no reset; a reset edge only schedules the sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == StClear) begin
                mem[cnt_q] <= CLEAR_VAL;
            end else if (wr_en) begin
                mem[wr_addr] <= wr_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StClear;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    rd_valid_q <= 1'b0;
                    cnt_q      <= cnt_q + ADDR'(1);
                    if (cnt_q == LastAddr) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StIdle: begin
                    rd_valid_q <= rd_en;
                    if (rd_en) begin
                        rd_data_q <= rd_word;
                    end
                    // Operations in the request cycle still complete; the sweep starts next edge.
                    if (clear_req) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dual_port_ram.sv
module tb_dual_port_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        clear_req;

    logic [15:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_port_ram #(.DATA(16), .ADDR(4), .RDW_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .clear_req(clear_req), .busy(busy0)
    );

    dual_port_ram #(.DATA(16), .ADDR(4), .RDW_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .clear_req(clear_req), .busy(busy1)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; clear_req = 1'b0;
    endtask

    // Counts settled samples with busy high, starting right after the triggering edge.
    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0; wr_be = '0;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (rd_data0 !== 16'h0000 || rd_valid0 !== 1'b0 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: rd_data=%h rd_valid=%b busy=%b, want 0000 0 1",
                     rd_data0, rd_valid0, busy0);
        end
        reset = 1'b0;
        count_busy(n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL reset_busy_len: busy high %0d cycles, want 16", n);
        end
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            tick();
            n_checks++;
            if (rd_data0 !== 16'h0000 || rd_valid0 !== 1'b1) begin
                n_fail++;
                $display("FAIL cleared_read[%0d]: rd_data=%h rd_valid=%b, want 0000 1",
                         a, rd_data0, rd_valid0);
            end
        end
        rd_en = 1'b0;
        tick();
        n_checks++;
        if (rd_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop: rd_valid=%b, want 0", rd_valid0);
        end
    endtask

    task automatic test_byte_enables();
        do_write(4'd3, 16'hABCD, 2'b11);
        do_write(4'd3, 16'h1234, 2'b01);
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_data0 !== 16'hAB34 || rd_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_enable_low: rd_data=%h rd_valid=%b, want ab34 1",
                     rd_data0, rd_valid0);
        end
        do_write(4'd3, 16'hFFFF, 2'b00);
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_data0 !== 16'hAB34) begin
            n_fail++;
            $display("FAIL byte_enable_none: rd_data=%h, want ab34", rd_data0);
        end
    endtask

    task automatic test_read_hold();
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        rd_en = 1'b0; rd_addr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (rd_data0 !== 16'hAB34 || rd_valid0 !== 1'b0) begin
                n_fail++;
                $display("FAIL read_hold[%0d]: rd_data=%h rd_valid=%b, want ab34 0",
                         i, rd_data0, rd_valid0);
            end
        end
    endtask

    task automatic test_collision();
        do_write(4'd5, 16'h1111, 2'b11);
        // Full-word collision.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h2222; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (rd_data0 !== 16'h1111) begin
            n_fail++;
            $display("FAIL collision_read_first: rd_data=%h, want 1111", rd_data0);
        end
        n_checks++;
        if (rd_data1 !== 16'h2222) begin
            n_fail++;
            $display("FAIL collision_write_first: rd_data=%h, want 2222", rd_data1);
        end
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_data0 !== 16'h2222 || rd_data1 !== 16'h2222) begin
            n_fail++;
            $display("FAIL collision_after: rd_data0=%h rd_data1=%h, want 2222", rd_data0, rd_data1);
        end
        // Partial-word collision: only the upper byte is written.
        do_write(4'd5, 16'h1111, 2'b11);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h22FF; wr_be = 2'b10;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (rd_data0 !== 16'h1111 || rd_data1 !== 16'h2211) begin
            n_fail++;
            $display("FAIL collision_partial: rd_data0=%h rd_data1=%h, want 1111 2211",
                     rd_data0, rd_data1);
        end
        // Different addresses do not forward.
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h7777; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (rd_data1 !== 16'h2211) begin
            n_fail++;
            $display("FAIL no_collision: rd_data1=%h, want 2211", rd_data1);
        end
    endtask

    task automatic test_clear_req();
        int n;
        bit bad_valid;
        clear_req = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h5555; wr_be = 2'b11;
        tick();
        clear_req = 1'b0; wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd7;
        n = 0;
        bad_valid = 1'b0;
        while (busy0 && n < 100) begin
            if (rd_valid0 !== 1'b0) bad_valid = 1'b1;
            n++;
            tick();
        end
        rd_en = 1'b0;
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL clear_busy_len: busy high %0d cycles, want 16", n);
        end
        n_checks++;
        if (bad_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ignores_read: rd_valid seen %b during busy, want 0", bad_valid);
        end
        rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_data0 !== 16'h0000 || rd_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_content: rd_data=%h rd_valid=%b, want 0000 1", rd_data0, rd_valid0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sweep_busy: busy=%b, want 1", busy0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL mid_sweep_restart: busy high %0d cycles, want 16", n);
        end
        n_checks++;
        if (busy1 !== 1'b0 || rd_data1 !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_sweep_end: busy=%b rd_data=%h, want 0 0000", busy1, rd_data1);
        end
    endtask

    initial begin
        test_reset();
        test_byte_enables();
        test_read_hold();
        test_collision();
        test_clear_req();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/dual_port_ram.md
# dual_port_ram

Parametrised simple-dual-port synchronous RAM: one write port and one read port, both on the same clock. It adds per-byte write enables, a selectable read-during-write collision mode and a hardware clear sequencer that sweeps every word to a programmable value. It is the general-purpose on-chip storage block for buffers and register files, and replaces the single-port memory unit where concurrent read and write or a known post-reset content is required.

## Interface
- DATA, 16: word width in bits; must be a multiple of 8.
- ADDR, 4: address width; depth = 2**ADDR words.
- RDW_MODE, 0: same-address read/write collision behaviour. 0 = read-first (old word); 1 = write-first (merged new word).
- CLEAR_VAL, {DATA{1'b0}}: value written to every word by the clear sequence.
- clk  in  1  single clock; all activity on the rising edge.
- reset  in  1  synchronous, active-high reset; also starts a clear sweep.
- wr_en  in  1  write request, sampled at clk rising edge.
- wr_addr  in  ADDR  write address.
- wr_be  in  DATA/8  byte enables; bit i gates wr_data[8i+7:8i].
- wr_data  in  DATA  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR  read address.
- rd_data  out  DATA  registered read data.
- rd_valid  out  1  high for one cycle when rd_data carries a new read result.
- clear_req  in  1  single-cycle request to start a clear sweep.
- busy  out  1  high while the clear sweep runs; both ports are ignored while it is high.

## Operation
- FSM states: IDLE and CLEAR. A 2-bit-free ADDR-wide sweep counter cnt is used only in CLEAR.
- Reset (edge with reset=1): state←CLEAR, cnt←0, busy←1, rd_data←0, rd_valid←0. Memory contents are not touched on a reset edge.
- CLEAR (reset=0): each edge writes mem[cnt]←CLEAR_VAL and increments cnt. The edge that writes address 2**ADDR-1 sets state←IDLE and busy←0. wr_en, rd_en and clear_req are ignored. rd_valid stays 0 and rd_data holds.
- IDLE write: if wr_en, for each i with wr_be[i]=1, byte i of mem[wr_addr] takes wr_data byte i. Other bytes are unchanged. wr_be=0 is a no-op.
- IDLE read: if rd_en, rd_data←mem[rd_addr] and rd_valid←1. Otherwise rd_valid←0 and rd_data holds its previous value.
- Collision (wr_en and rd_en both high, wr_addr==rd_addr):
  - RDW_MODE=0: rd_data gets the pre-write word.
  - RDW_MODE=1: rd_data gets the post-write word, i.e. enabled bytes come from wr_data and the rest from the old word.
- clear_req in IDLE: a read or write in the same cycle is still performed. Next edge: state←CLEAR, cnt←0, busy←1.
- Reset asserted during CLEAR restarts the sweep from cnt=0.
- Reset asserted during IDLE aborts any pending operation and starts a full sweep.

## Timing
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_data/rd_valid valid after edge N.
- Write latency is 1 cycle: data written at edge N is readable by a read issued at edge N+1.
- Clear duration is exactly 2**ADDR cycles. busy is high from the edge after the reset/clear_req cycle through the edge that writes the last word. With ADDR=4, busy is high for 16 cycles after reset is released.
- The first accepted operation is in the cycle after busy falls.
- Outputs after reset: rd_data=0, rd_valid=0, busy=1.

## Test plan
- Reset 2 cycles, release → busy high for exactly 16 cycles, then 0. Read addresses 0..15 back-to-back → rd_data=0x0000 for each, rd_valid high one cycle after each rd_en.
- Write addr 3 0xABCD with be=2'b11, then addr 3 0x1234 with be=2'b01. Read 3 → 0xAB34. A write with be=2'b00 leaves 0xAB34.
- RDW_MODE=0: mem[5]=0x1111. In the same cycle write 0x2222 (be=11) and read 5 → rd_data=0x1111; the next read of 5 → 0x2222. RDW_MODE=1 with be=2'b10, wr_data 0x22FF → rd_data=0x2211 in the collision cycle.
- In IDLE, clear_req with a simultaneous write of 0x5555 to addr 7 → busy high 16 cycles. rd_en held high during busy → rd_valid stays 0. After busy falls, read 7 → 0x0000.
- Reset pulsed when cnt=8 mid-sweep → busy stays high and falls exactly 16 cycles after reset release.
- Read addr 3 (0xAB34), then rd_en low for 3 cycles → rd_data holds 0xAB34 and rd_valid=0 throughout.
